// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM cores and their downstream dead-time stages.
// State encoding, register offsets (addr[5:2]) and CTRL/STATUS bit positions.
package pwm_pkg;

  typedef enum logic [2:0] {
    ST_OFF  = 3'd0,
    ST_LO   = 3'd1,
    ST_DT_H = 3'd2,
    ST_HI   = 3'd3,
    ST_DT_L = 3'd4
  } state_e;

  localparam logic [3:0] OFS_CTRL     = 4'd0;
  localparam logic [3:0] OFS_DEADTIME = 4'd1;
  localparam logic [3:0] OFS_STATUS   = 4'd2;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_HI_POL = 1;
  localparam int CTRL_LO_POL = 2;

  localparam int STATUS_SHORT = 3;
  localparam int STATUS_PWM   = 4;

  localparam int DT_FALL_LSB = 16;

  // Gate drive levels {hi, lo} for a state, before polarity is applied.
  function automatic logic [1:0] drive_of(state_e s);
    logic [1:0] d;
    d = 2'b00;
    case (s)
      ST_LO:   d = 2'b01;
      ST_HI:   d = 2'b10;
      default: d = 2'b00;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pwm_deadtime_regs.sv
// Register slot of the dead-time stage: valid/ready bus handshake,
// CTRL/DEADTIME storage and the sticky short_pulse flag with write-1-to-clear.
module pwm_deadtime_regs
  import pwm_pkg::*;
#(
  parameter int BITS    = 32,
  parameter int DT_BITS = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [BITS-1:0]    wdata_i,
  output logic [BITS-1:0]    rdata_o,
  input  state_e             state_i,
  input  logic               short_set_i,
  input  logic               pwm_i,
  output logic               en_o,
  output logic               hi_pol_o,
  output logic               lo_pol_o,
  output logic [DT_BITS-1:0] rise_dt_o,
  output logic [DT_BITS-1:0] fall_dt_o
);

  // Handshake: a request is accepted when valid_i is high and ready_o is low;
  // the ack (ready_o) follows one edge later and lasts exactly one cycle, so a
  // held valid_i is acknowledged every other cycle. Read data rides with the ack.
  logic            acc;
  logic            wr;
  logic            rd;
  logic [3:0]      ofs;
  logic            short_q;
  logic            short_clr;
  logic [BITS-1:0] rd_val;
  logic            unused_bits;

  assign acc       = valid_i & ~ready_o;
  assign wr        = acc & we_i;
  assign rd        = acc & ~we_i;
  assign ofs       = addr_i[5:2];
  assign short_clr = wr && (ofs == OFS_STATUS) && wdata_i[STATUS_SHORT];

  assign unused_bits = ^{addr_i, wdata_i};

  always_comb begin
    rd_val = '0;
    case (ofs)
      OFS_CTRL: begin
        rd_val[CTRL_EN]     = en_o;
        rd_val[CTRL_HI_POL] = hi_pol_o;
        rd_val[CTRL_LO_POL] = lo_pol_o;
      end
      OFS_DEADTIME: begin
        rd_val[DT_BITS-1:0]            = rise_dt_o;
        rd_val[DT_FALL_LSB +: DT_BITS] = fall_dt_o;
      end
      OFS_STATUS: begin
        rd_val[2:0]          = state_i;
        rd_val[STATUS_SHORT] = short_q;
        rd_val[STATUS_PWM]   = pwm_i;
      end
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_o   <= 1'b0;
      rdata_o   <= '0;
      en_o      <= 1'b0;
      hi_pol_o  <= 1'b0;
      lo_pol_o  <= 1'b0;
      rise_dt_o <= '0;
      fall_dt_o <= '0;
      short_q   <= 1'b0;
    end else begin
      ready_o <= acc;
      rdata_o <= rd ? rd_val : '0;
      if (wr && ofs == OFS_CTRL) begin
        en_o     <= wdata_i[CTRL_EN];
        hi_pol_o <= wdata_i[CTRL_HI_POL];
        lo_pol_o <= wdata_i[CTRL_LO_POL];
      end
      if (wr && ofs == OFS_DEADTIME) begin
        rise_dt_o <= wdata_i[DT_BITS-1:0];
        fall_dt_o <= wdata_i[DT_FALL_LSB +: DT_BITS];
      end
      // A new short pulse on the clearing edge must not be lost.
      short_q <= short_set_i | (short_q & ~short_clr);
    end
  end

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary high/low gate drive generator with programmable dead time on both
// edges of the incoming PWM wave; FSM, dead-time counter and output flops.
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int BITS    = 32,
  parameter int DT_BITS = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            we_i,
  input  logic [31:0]     addr_i,
  input  logic [BITS-1:0] wdata_i,
  output logic [BITS-1:0] rdata_o,
  input  logic            pwm_i,
  output logic            pwm_hi_o,
  output logic            pwm_lo_o
);

  localparam logic [DT_BITS-1:0] DT_ONE = DT_BITS'(1);

  logic               en;
  logic               hi_pol;
  logic               lo_pol;
  logic [DT_BITS-1:0] rise_dt;
  logic [DT_BITS-1:0] fall_dt;
  state_e             state_q;
  state_e             state_d;
  logic [DT_BITS-1:0] cnt_q;
  logic [DT_BITS-1:0] cnt_d;
  logic               short_set;
  logic [1:0]         drive_d;

  pwm_deadtime_regs #(
    .BITS    (BITS),
    .DT_BITS (DT_BITS)
  ) u_regs (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rdata_o     (rdata_o),
    .state_i     (state_q),
    .short_set_i (short_set),
    .pwm_i       (pwm_i),
    .en_o        (en),
    .hi_pol_o    (hi_pol),
    .lo_pol_o    (lo_pol),
    .rise_dt_o   (rise_dt),
    .fall_dt_o   (fall_dt)
  );

  // The counter is loaded only on entry to a dead-time state, so DEADTIME
  // writes never disturb a gap already in progress.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    short_set = 1'b0;
    if (!en) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: state_d = pwm_i ? ST_HI : ST_LO;
        ST_LO: begin
          if (pwm_i) begin
            if (rise_dt == '0) begin
              state_d = ST_HI;
            end else begin
              state_d = ST_DT_H;
              cnt_d   = rise_dt - DT_ONE;
            end
          end
        end
        ST_DT_H: begin
          if (!pwm_i) begin
            state_d   = ST_LO;
            short_set = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = ST_HI;
          end else begin
            cnt_d = cnt_q - DT_ONE;
          end
        end
        ST_HI: begin
          if (!pwm_i) begin
            if (fall_dt == '0) begin
              state_d = ST_LO;
            end else begin
              state_d = ST_DT_L;
              cnt_d   = fall_dt - DT_ONE;
            end
          end
        end
        ST_DT_L: begin
          if (pwm_i) begin
            state_d   = ST_HI;
            short_set = 1'b1;
          end else if (cnt_q == '0) begin
            state_d = ST_LO;
          end else begin
            cnt_d = cnt_q - DT_ONE;
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
    drive_d = drive_of(state_d);
  end

  // Outputs are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      pwm_hi_o <= 1'b0;
      pwm_lo_o <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pwm_hi_o <= drive_d[1] ^ hi_pol;
      pwm_lo_o <= drive_d[0] ^ lo_pol;
    end
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// Self-checking bench for pwm_deadtime: bus reads and gate drive levels are
// predicted when stimulus is driven and compared when the DUT responds.
module tb_pwm_deadtime;

  logic        clk_i   = 1'b0;
  logic        rst_ni  = 1'b0;
  logic        valid_i = 1'b0;
  logic        we_i    = 1'b0;
  logic [31:0] addr_i  = '0;
  logic [31:0] wdata_i = '0;
  logic        pwm_i   = 1'b0;
  logic        ready_o;
  logic [31:0] rdata_o;
  logic        pwm_hi_o;
  logic        pwm_lo_o;

  logic [31:0] rd_q[$];
  logic [1:0]  exp_q[$];

  int checks = 0;
  int errors = 0;

  pwm_deadtime #(.BITS(32), .DT_BITS(8)) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rdata_o  (rdata_o),
    .pwm_i    (pwm_i),
    .pwm_hi_o (pwm_hi_o),
    .pwm_lo_o (pwm_lo_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All driver tasks start and end on a falling edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr_i  = a;
    wdata_i = d;
    we_i    = 1'b1;
    valid_i = 1'b1;
    @(negedge clk_i);
    check("wr_ack", {31'b0, ready_o}, 32'd1);
    valid_i = 1'b0;
    we_i    = 1'b0;
    @(negedge clk_i);
    check("wr_ack_drop", {31'b0, ready_o}, 32'd0);
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] e;
    rd_q.push_back(exp);
    addr_i  = a;
    we_i    = 1'b0;
    valid_i = 1'b1;
    @(negedge clk_i);
    check("rd_ack", {31'b0, ready_o}, 32'd1);
    valid_i = 1'b0;
    e = rd_q.pop_front();
    check(tag, rdata_o, e);
    @(negedge clk_i);
    check("rd_idle", rdata_o, 32'd0);
  endtask

  task automatic step(input logic p, input logic eh, input logic el, input string tag);
    logic [1:0] e;
    pwm_i = p;
    exp_q.push_back({eh, el});
    @(negedge clk_i);
    e = exp_q.pop_front();
    check(tag, {30'b0, pwm_hi_o, pwm_lo_o}, {30'b0, e});
  endtask

  initial begin
    logic r;
    // 1: reset state and register reads
    #1;
    check("rst_outs", {30'b0, pwm_hi_o, pwm_lo_o}, 32'd0);
    check("rst_ready", {31'b0, ready_o}, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    bus_read(32'h0, 32'h0, "rd_ctrl_rst");
    bus_read(32'h4, 32'h0, "rd_dt_rst");
    bus_read(32'h8, 32'h0, "rd_status_rst");
    check("idle_outs", {30'b0, pwm_hi_o, pwm_lo_o}, 32'd0);

    // 2: rise_dt=4, fall_dt=6
    bus_write(32'h0, 32'h1);
    bus_write(32'h4, 32'h0006_0004);
    step(1'b0, 1'b0, 1'b1, "lo_idle");
    step(1'b0, 1'b0, 1'b1, "lo_idle");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, "rise_gap");
    step(1'b1, 1'b1, 1'b0, "hi_on");
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0, "hi_hold");
    bus_read(32'h8, 32'h13, "rd_status_hi");
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, "fall_gap");
    step(1'b0, 1'b0, 1'b1, "lo_on");

    // 3: zero dead time follows pwm_i one edge later
    bus_write(32'h4, 32'h0);
    for (int i = 0; i < 16; i++) begin
      r = 1'($urandom_range(0, 1));
      step(r, r, ~r, "zero_dt");
    end

    // 4: short pulse swallowed by an 8-cycle rise gap
    step(1'b0, 1'b0, 1'b1, "lo_before_short");
    bus_write(32'h4, 32'h8);
    step(1'b0, 1'b0, 1'b1, "lo_idle2");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, "short_gap");
    step(1'b0, 1'b0, 1'b1, "short_lo_back");
    bus_read(32'h8, 32'h09, "rd_short_set");
    bus_write(32'h8, 32'h8);
    bus_read(32'h8, 32'h01, "rd_short_clr");

    // 5: polarity, disable, and async reset mid-gap
    bus_write(32'h0, 32'h7);
    step(1'b0, 1'b1, 1'b0, "pol_lo");
    bus_write(32'h0, 32'h6);
    step(1'b0, 1'b1, 1'b1, "pol_off");
    bus_write(32'h0, 32'h7);
    step(1'b0, 1'b1, 1'b0, "pol_lo2");
    step(1'b1, 1'b1, 1'b1, "pol_gap");
    step(1'b1, 1'b1, 1'b1, "pol_gap");
    rst_ni = 1'b0;
    #1;
    check("rst_mid_gap", {30'b0, pwm_hi_o, pwm_lo_o}, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    pwm_i  = 1'b0;
    @(negedge clk_i);
    bus_read(32'h0, 32'h0, "rd_ctrl_after_rst");

    // 6: DEADTIME rewritten mid-count applies only to the next gap
    bus_write(32'h0, 32'h1);
    bus_write(32'h4, 32'h0008_0008);
    step(1'b0, 1'b0, 1'b1, "lo_idle3");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, "old_gap");
    bus_write(32'h4, 32'h0002_0002);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, "old_gap_tail");
    step(1'b1, 1'b1, 1'b0, "old_gap_hi");
    step(1'b0, 1'b0, 1'b0, "new_fall_gap");
    step(1'b0, 1'b0, 1'b0, "new_fall_gap");
    step(1'b0, 1'b0, 1'b1, "new_fall_lo");
    step(1'b1, 1'b0, 1'b0, "new_rise_gap");
    step(1'b1, 1'b0, 1'b0, "new_rise_gap");
    step(1'b1, 1'b1, 1'b0, "new_rise_hi");
    bus_read(32'hC, 32'h0, "rd_unmapped");
    bus_write(32'hC, 32'hFFFF_FFFF);
    bus_read(32'h0, 32'h1, "rd_ctrl_kept");
    bus_read(32'h4, 32'h0002_0002, "rd_dt_kept");
    bus_read(32'h8, 32'h13, "rd_status_kept");
    step(1'b1, 1'b1, 1'b0, "hi_kept");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
